// File: rtl/skew_stream_collector.sv
// Rebuilds an NxN matrix from N skewed wavefront beats (2N-1 lanes), accumulating
// per-lane sums and flagging orientation or padding faults, then offers the frame downstream.
//
// state   | meaning
// COLLECT | accepting beats 0..N-1, in_ready=1
// HOLD    | frame complete, out_valid=1 until out_ready
module skew_stream_collector #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8,
  parameter int SUM_WIDTH  = DATA_WIDTH + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  row_sel,
  input  logic [DATA_WIDTH-1:0] in_data        [0:2*N-2],
  input  logic                  in_lane_valid  [0:2*N-2],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_matrix     [0:N-1][0:N-1],
  output logic                  out_elem_valid [0:N-1][0:N-1],
  output logic [SUM_WIDTH-1:0]  out_lane_sum   [0:2*N-2],
  output logic                  frame_err
);

  localparam int L  = 2*N - 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                state, state_nxt;
  logic [BW-1:0]         beat;
  logic                  row_lat;
  logic                  accept, release_frame;
  logic                  row_eff, mode_err, pad_nz;
  logic [DATA_WIDTH-1:0] win_data  [0:N-1];
  logic                  win_valid [0:N-1];

  assign in_ready      = (state == COLLECT);
  assign out_valid     = (state == HOLD);
  assign accept        = in_valid && (state == COLLECT);
  assign release_frame = out_ready && (state == HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (in_valid && beat == BW'(N-1)) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  // Orientation for beat 0 comes straight from the port; later beats use the latched value.
  always_comb begin
    row_eff  = (beat == '0) ? row_sel : row_lat;
    mode_err = (beat != '0) && (row_sel != row_lat);
    pad_nz   = 1'b0;
    for (int j = 0; j < N; j++) begin
      win_valid[j] = in_lane_valid[LW'(beat) + LW'(j)];
      win_data[j]  = win_valid[j] ? in_data[LW'(beat) + LW'(j)] : '0;
    end
    for (int l = 0; l < L; l++) begin
      if ((l < int'(beat) || l > int'(beat) + N - 1) && in_data[LW'(l)] != '0)
        pad_nz = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || release_frame) begin
      beat      <= '0;
      row_lat   <= 1'b0;
      frame_err <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          out_matrix[r][c]     <= '0;
          out_elem_valid[r][c] <= 1'b0;
        end
      end
      for (int l = 0; l < L; l++) out_lane_sum[l] <= '0;
    end else if (accept) begin
      if (beat == '0) row_lat <= row_sel;
      if (mode_err || pad_nz) frame_err <= 1'b1;
      for (int j = 0; j < N; j++) begin
        if (row_eff) begin
          out_matrix[beat][BW'(j)]     <= win_data[j];
          out_elem_valid[beat][BW'(j)] <= win_valid[j];
        end else begin
          out_matrix[BW'(j)][beat]     <= win_data[j];
          out_elem_valid[BW'(j)][beat] <= win_valid[j];
        end
        out_lane_sum[LW'(beat) + LW'(j)] <=
          out_lane_sum[LW'(beat) + LW'(j)] + SUM_WIDTH'(win_data[j]);
      end
      beat <= (beat == BW'(N-1)) ? '0 : beat + 1'b1;
    end
  end

endmodule

// File: tb/tb_skew_stream_collector.sv
// Drives skewed frames built from a logical matrix and checks the rebuilt matrix,
// anti-diagonal sums and fault flag against a matrix-level reference model.
module tb_skew_stream_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       row_sel = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data        [0:4];
  logic       in_lane_valid  [0:4];
  logic       in_ready, out_valid, frame_err;
  logic [7:0] out_matrix     [0:2][0:2];
  logic       out_elem_valid [0:2][0:2];
  logic [9:0] out_lane_sum   [0:4];

  int vectors = 0;
  int miscompares = 0;

  // Frame description used by the stimulus and the reference model
  logic [7:0] src  [0:2][0:2];
  bit         vsrc [0:2][0:2];
  bit         row_mode;
  int         flip_beat, pad_beat, pad_lane, gap_max;
  logic [7:0] pad_val;

  skew_stream_collector #(.N(3), .DATA_WIDTH(8), .SUM_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .row_sel(row_sel), .in_data(in_data), .in_lane_valid(in_lane_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_matrix(out_matrix),
    .out_elem_valid(out_elem_valid), .out_lane_sum(out_lane_sum), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic junk_inputs(input logic v);
    in_valid = v;
    row_sel  = 1'($urandom_range(0, 1));
    for (int l = 0; l < 5; l++) begin
      in_data[l]       = 8'($urandom);
      in_lane_valid[l] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic set_defaults();
    flip_beat = -1; pad_beat = -1; pad_lane = 0; pad_val = 8'd0; gap_max = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) vsrc[r][c] = 1'b1;
  endtask

  task automatic drive_frame(input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(negedge clk);
        junk_inputs(1'b0);
      end
      @(negedge clk);
      for (int l = 0; l < 5; l++) begin
        in_data[l]       = 8'd0;
        in_lane_valid[l] = 1'($urandom_range(0, 1));
      end
      for (int j = 0; j < 3; j++) begin
        int r, c;
        r = row_mode ? b : j;
        c = row_mode ? j : b;
        in_data[b+j]       = src[r][c];
        in_lane_valid[b+j] = vsrc[r][c];
      end
      if (b == pad_beat) in_data[pad_lane] = pad_val;
      row_sel  = row_mode ^ (b == flip_beat);
      in_valid = 1'b1;
      chk($sformatf("in_ready beat%0d", b), in_ready, 1);
      chk($sformatf("out_valid early beat%0d", b), out_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    junk_inputs(1'b0);
  endtask

  task automatic check_result(input string tag);
    logic [9:0] exp_sum [0:4];
    bit exp_err;
    for (int k = 0; k < 5; k++) exp_sum[k] = 10'd0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (vsrc[r][c]) exp_sum[r+c] += 10'(src[r][c]);
    exp_err = (flip_beat > 0) || (pad_beat >= 0 && pad_val != 8'd0);
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " frame_err"}, frame_err, exp_err);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("%s m[%0d][%0d]", tag, r, c), out_matrix[r][c], vsrc[r][c] ? src[r][c] : 8'd0);
        chk($sformatf("%s ev[%0d][%0d]", tag, r, c), out_elem_valid[r][c], vsrc[r][c]);
      end
    for (int k = 0; k < 5; k++)
      chk($sformatf("%s sum[%0d]", tag, k), out_lane_sum[k], exp_sum[k]);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " in_ready"}, in_ready, 1);
    chk({tag, " frame_err"}, frame_err, 0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        chk($sformatf("%s ev[%0d][%0d]", tag, r, c), out_elem_valid[r][c], 0);
    for (int k = 0; k < 5; k++)
      chk($sformatf("%s sum[%0d]", tag, k), out_lane_sum[k], 0);
  endtask

  task automatic hold_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      junk_inputs(1'b1);
      @(posedge clk);
      @(negedge clk);
      check_result($sformatf("%s hold%0d", tag, i));
    end
    junk_inputs(1'b0);
  endtask

  task automatic release_frame(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_cleared({tag, " released"});
  endtask

  task automatic run_frame(input string tag, input int hold_n);
    drive_frame(3);
    check_result(tag);
    hold_cycles(tag, hold_n);
    release_frame(tag);
  endtask

  task automatic load_seq_matrix();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) src[r][c] = 8'(3*r + c + 1);
  endtask

  initial begin
    junk_inputs(1'b0);
    set_defaults();
    row_mode = 1'b1;
    load_seq_matrix();
    repeat (2) @(negedge clk);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) chk($sformatf("reset m[%0d][%0d]", r, c), out_matrix[r][c], 0);
    check_cleared("reset");
    rst_n = 1'b1;

    // Row mode, sequential matrix
    drive_frame(3);
    check_result("t1_row");
    chk("t1 sum2 const", out_lane_sum[2], 15);
    chk("t1 sum3 const", out_lane_sum[3], 14);
    release_frame("t1");

    // Column mode, same logical matrix
    row_mode = 1'b0;
    run_frame("t2_col", 0);

    // All 255, stalled output
    row_mode = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) src[r][c] = 8'hFF;
    drive_frame(3);
    check_result("t3_max");
    chk("t3 sum2 const", out_lane_sum[2], 765);
    chk("t3 sum0 const", out_lane_sum[0], 255);
    hold_cycles("t3", 5);
    release_frame("t3");

    // Invalid lane, then nonzero padding
    load_seq_matrix();
    vsrc[1][2] = 1'b0;
    drive_frame(3);
    check_result("t4_lv");
    chk("t4 sum3 const", out_lane_sum[3], 8);
    release_frame("t4");
    set_defaults();
    pad_beat = 1; pad_lane = 0; pad_val = 8'h33;
    run_frame("t4_pad", 1);

    // Orientation toggle on beat 2 with gaps, then gaps alone
    set_defaults();
    row_mode = 1'b0; flip_beat = 2; gap_max = 3;
    run_frame("t5_flip", 0);
    set_defaults();
    gap_max = 3;
    run_frame("t5_gap", 0);

    // Reset mid-frame, then replay row-mode frame
    set_defaults();
    row_mode = 1'b1;
    drive_frame(2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_cleared("t6 reset");
    drive_frame(3);
    check_result("t6_replay");
    release_frame("t6");

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      set_defaults();
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          src[r][c]  = 8'($urandom);
          vsrc[r][c] = ($urandom_range(0, 3) != 0);
        end
      row_mode = 1'($urandom_range(0, 1));
      gap_max  = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) flip_beat = $urandom_range(1, 2);
      if ($urandom_range(0, 3) == 0) begin
        pad_beat = $urandom_range(0, 2);
        pad_lane = (pad_beat + 3 + $urandom_range(0, 1)) % 5;
        pad_val  = 8'($urandom_range(0, 255));
      end
      run_frame($sformatf("rnd%0d", f), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
